ctrl_pipe: RTL and testbench

- Consumer of the packed control bundles (WB/EX/MEM) and the jump/branch flags that the ID-stage decoder produces.
- Carries control through the ID/EX, EX/MEM and MEM/WB pipeline registers and unpacks it into named per-stage signals.
- Tracks the destination register number per stage.
- Detects load-use hazards (stall plus bubble) and raises the IF/ID flush for jumps and taken branches.

---
 rtl/ctrl_pipe.sv | 166 ++++++++++++++++
 tb/tb_ctrl_pipe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoded control from ID through the ID/EX, EX/MEM and
// MEM/WB pipeline registers and unpacks it into named per-stage signals.
// It also tracks the destination register per stage, detects load-use
// hazards, and raises the IF/ID flush for jumps and taken branches.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   WB_i {RegWrite, MemtoReg}, EX_i {ALUSrc, ALUOp[1:0], RegDst},
//   MEM_i {MemRead, MemWrite}, jumpCtrl_i, brenchCtrl_i, branchEq_i,
//   rs_i / rt_i / rd_i       register fields of the ID instruction
//   stall_o, flush_o         combinational hazard / flush requests
//   ex_*  / mem_* / wb_*     unpacked ID/EX, EX/MEM, MEM/WB control
module ctrl_pipe #(
  parameter int REG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       WB_i,
  input  logic [3:0]       EX_i,
  input  logic [1:0]       MEM_i,
  input  logic             jumpCtrl_i,
  input  logic             brenchCtrl_i,
  input  logic             branchEq_i,
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic [REG_W-1:0] rd_i,
  output logic             stall_o,
  output logic             flush_o,
  output logic             ex_ALUSrc_o,
  output logic             ex_RegDst_o,
  output logic [1:0]       ex_ALUOp_o,
  output logic             ex_RegWrite_o,
  output logic             ex_MemRead_o,
  output logic [REG_W-1:0] ex_WriteReg_o,
  output logic             mem_MemRead_o,
  output logic             mem_MemWrite_o,
  output logic             mem_RegWrite_o,
  output logic [REG_W-1:0] mem_WriteReg_o,
  output logic             wb_RegWrite_o,
  output logic             wb_MemtoReg_o,
  output logic [REG_W-1:0] wb_WriteReg_o
);

  // ID stage: destination select, hazard detection, bubble mux
  logic             alu_src_p0, reg_dst_p0, reg_write_p0, mem_to_reg_p0;
  logic             mem_read_p0, mem_write_p0;
  logic [1:0]       alu_op_p0;
  logic [REG_W-1:0] wreg_p0;

  logic             mem_read_p1, mem_write_p1, reg_write_p1, mem_to_reg_p1;
  logic [REG_W-1:0] wreg_p1;

  logic             reg_write_p2, mem_to_reg_p2;
  logic [REG_W-1:0] wreg_p2;

  logic             stall;
  logic [REG_W-1:0] dst_id;
  logic             alu_src_d, reg_dst_d, reg_write_d, mem_to_reg_d;
  logic             mem_read_d, mem_write_d;
  logic [1:0]       alu_op_d;
  logic [REG_W-1:0] wreg_d;

  assign stall = mem_read_p0 && (wreg_p0 != '0) &&
                 ((wreg_p0 == rs_i) || (wreg_p0 == rt_i));

  always_comb begin
    // RegWrite gates the select first, so an X RegDst on beq/j/sw never
    // reaches the destination or the hazard compare.
    dst_id = '0;
    if (WB_i[1]) begin
      dst_id = EX_i[0] ? rt_i : rd_i;
    end

    alu_src_d    = EX_i[3];
    alu_op_d     = EX_i[2:1];
    reg_dst_d    = EX_i[0];
    reg_write_d  = WB_i[1];
    mem_to_reg_d = WB_i[0];
    mem_read_d   = MEM_i[1];
    mem_write_d  = MEM_i[0];
    wreg_d       = dst_id;
    if (stall) begin
      alu_src_d    = 1'b0;
      alu_op_d     = 2'b00;
      reg_dst_d    = 1'b0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      wreg_d       = '0;
    end
  end

  // ID/EX register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      alu_src_p0    <= 1'b0;
      alu_op_p0     <= 2'b00;
      reg_dst_p0    <= 1'b0;
      reg_write_p0  <= 1'b0;
      mem_to_reg_p0 <= 1'b0;
      mem_read_p0   <= 1'b0;
      mem_write_p0  <= 1'b0;
      wreg_p0       <= '0;
    end else begin
      alu_src_p0    <= alu_src_d;
      alu_op_p0     <= alu_op_d;
      reg_dst_p0    <= reg_dst_d;
      reg_write_p0  <= reg_write_d;
      mem_to_reg_p0 <= mem_to_reg_d;
      mem_read_p0   <= mem_read_d;
      mem_write_p0  <= mem_write_d;
      wreg_p0       <= wreg_d;
    end
  end

  // EX/MEM register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      wreg_p1       <= '0;
    end else begin
      mem_read_p1   <= mem_read_p0;
      mem_write_p1  <= mem_write_p0;
      reg_write_p1  <= reg_write_p0;
      mem_to_reg_p1 <= mem_to_reg_p0;
      wreg_p1       <= wreg_p0;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      reg_write_p2  <= 1'b0;
      mem_to_reg_p2 <= 1'b0;
      wreg_p2       <= '0;
    end else begin
      reg_write_p2  <= reg_write_p1;
      mem_to_reg_p2 <= mem_to_reg_p1;
      wreg_p2       <= wreg_p1;
    end
  end

  assign stall_o        = stall;
  assign flush_o        = (jumpCtrl_i || (brenchCtrl_i && branchEq_i)) && !stall;

  assign ex_ALUSrc_o    = alu_src_p0;
  assign ex_RegDst_o    = reg_dst_p0;
  assign ex_ALUOp_o     = alu_op_p0;
  assign ex_RegWrite_o  = reg_write_p0;
  assign ex_MemRead_o   = mem_read_p0;
  assign ex_WriteReg_o  = wreg_p0;

  assign mem_MemRead_o  = mem_read_p1;
  assign mem_MemWrite_o = mem_write_p1;
  assign mem_RegWrite_o = reg_write_p1;
  assign mem_WriteReg_o = wreg_p1;

  assign wb_RegWrite_o  = reg_write_p2;
  assign wb_MemtoReg_o  = mem_to_reg_p2;
  assign wb_WriteReg_o  = wreg_p2;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: expected per-stage control bundles are
// pushed into a scoreboard as each instruction is presented and compared
// against the ex_/mem_/wb_ outputs as the instruction moves down the pipe.
module tb_ctrl_pipe;
  localparam int REG_W = 5;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic [1:0]       WB_i = '0;
  logic [3:0]       EX_i = '0;
  logic [1:0]       MEM_i = '0;
  logic             jumpCtrl_i = 1'b0, brenchCtrl_i = 1'b0, branchEq_i = 1'b0;
  logic [REG_W-1:0] rs_i = '0, rt_i = '0, rd_i = '0;
  logic             stall_o, flush_o;
  logic             ex_ALUSrc_o, ex_RegDst_o, ex_RegWrite_o, ex_MemRead_o;
  logic [1:0]       ex_ALUOp_o;
  logic [REG_W-1:0] ex_WriteReg_o, mem_WriteReg_o, wb_WriteReg_o;
  logic             mem_MemRead_o, mem_MemWrite_o, mem_RegWrite_o;
  logic             wb_RegWrite_o, wb_MemtoReg_o;

  ctrl_pipe #(.REG_W(REG_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .WB_i(WB_i), .EX_i(EX_i), .MEM_i(MEM_i),
    .jumpCtrl_i(jumpCtrl_i), .brenchCtrl_i(brenchCtrl_i), .branchEq_i(branchEq_i),
    .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .stall_o(stall_o), .flush_o(flush_o),
    .ex_ALUSrc_o(ex_ALUSrc_o), .ex_RegDst_o(ex_RegDst_o), .ex_ALUOp_o(ex_ALUOp_o),
    .ex_RegWrite_o(ex_RegWrite_o), .ex_MemRead_o(ex_MemRead_o),
    .ex_WriteReg_o(ex_WriteReg_o), .mem_MemRead_o(mem_MemRead_o),
    .mem_MemWrite_o(mem_MemWrite_o), .mem_RegWrite_o(mem_RegWrite_o),
    .mem_WriteReg_o(mem_WriteReg_o), .wb_RegWrite_o(wb_RegWrite_o),
    .wb_MemtoReg_o(wb_MemtoReg_o), .wb_WriteReg_o(wb_WriteReg_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic             alusrc;
    logic [1:0]       aluop;
    logic             regdst;
    logic             regwrite;
    logic             memtoreg;
    logic             memread;
    logic             memwrite;
    logic [REG_W-1:0] wreg;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t decode(input logic [1:0] wb, input logic [3:0] ex,
                                  input logic [1:0] mem, input logic [REG_W-1:0] rt,
                                  input logic [REG_W-1:0] rd, input logic bubble);
    exp_t e;
    e = '0;
    if (!bubble) begin
      e.alusrc   = ex[3];
      e.aluop    = ex[2:1];
      e.regdst   = ex[0];
      e.regwrite = wb[1];
      e.memtoreg = wb[0];
      e.memread  = mem[1];
      e.memwrite = mem[0];
      e.wreg     = wb[1] ? (ex[0] ? rt : rd) : '0;
    end
    return e;
  endfunction

  task automatic sb_reset();
    sb.delete();
    repeat (3) sb.push_back('0);
  endtask

  task automatic check_stages(input string tag);
    exp_t e_ex, e_mem, e_wb;
    e_ex  = sb[2];
    e_mem = sb[1];
    e_wb  = sb[0];
    chk({tag, ".ex"},
        {21'd0, ex_ALUSrc_o, ex_ALUOp_o, ex_RegDst_o, ex_RegWrite_o, ex_MemRead_o, ex_WriteReg_o},
        {21'd0, e_ex.alusrc, e_ex.aluop, e_ex.regdst, e_ex.regwrite, e_ex.memread, e_ex.wreg});
    chk({tag, ".mem"},
        {23'd0, mem_MemRead_o, mem_MemWrite_o, mem_RegWrite_o, mem_WriteReg_o},
        {23'd0, e_mem.memread, e_mem.memwrite, e_mem.regwrite, e_mem.wreg});
    chk({tag, ".wb"},
        {25'd0, wb_RegWrite_o, wb_MemtoReg_o, wb_WriteReg_o},
        {25'd0, e_wb.regwrite, e_wb.memtoreg, e_wb.wreg});
  endtask

  // Called at a negedge; presents one ID instruction, checks stall/flush,
  // clocks it in and checks every stage. Returns at the next negedge.
  task automatic drive(input string tag, input logic [1:0] wb, input logic [3:0] ex,
                       input logic [1:0] mem, input logic j, input logic br, input logic eq,
                       input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                       input logic [REG_W-1:0] rd, input logic exp_stall,
                       input logic exp_flush);
    WB_i = wb; EX_i = ex; MEM_i = mem;
    jumpCtrl_i = j; brenchCtrl_i = br; branchEq_i = eq;
    rs_i = rs; rt_i = rt; rd_i = rd;
    #1;
    chk({tag, ".stall"}, {31'd0, stall_o}, {31'd0, exp_stall});
    chk({tag, ".flush"}, {31'd0, flush_o}, {31'd0, exp_flush});
    @(posedge clk_i);
    sb.push_back(decode(wb, ex, mem, rt, rd, exp_stall));
    void'(sb.pop_front());
    #1;
    check_stages(tag);
    @(negedge clk_i);
  endtask

  task automatic nop(input string tag);
    drive(tag, 2'b00, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sb_reset();
    // Reset held with all control inputs asserted
    WB_i = 2'b11; EX_i = 4'b1111; MEM_i = 2'b11;
    repeat (2) @(posedge clk_i);
    #1;
    check_stages("reset");
    chk("reset.stall", {31'd0, stall_o}, 32'd0);
    chk("reset.flush", {31'd0, flush_o}, 32'd0);
    jumpCtrl_i = 1'b1;
    #1;
    chk("reset.flush_j", {31'd0, flush_o}, 32'd1);
    jumpCtrl_i = 1'b0;

    @(negedge clk_i);
    rst_i = 1'b1;
    drive("rel", 2'b11, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 5'd1, 5'd7, 5'd2, 1'b0, 1'b0);
    chk("rel.alusrc", {31'd0, ex_ALUSrc_o}, 32'd1);
    chk("rel.aluop", {30'd0, ex_ALUOp_o}, 32'd3);

    // addi, latency through all three stages
    drive("addi", 2'b10, 4'b0001, 2'b00, 1'b0, 1'b0, 1'b0, 5'd1, 5'd8, 5'd3, 1'b0, 1'b0);
    chk("addi.ex_dst", {27'd0, ex_WriteReg_o}, 32'd8);
    drive("rtype", 2'b10, 4'b1100, 2'b00, 1'b0, 1'b0, 1'b0, 5'd2, 5'd9, 5'd12, 1'b0, 1'b0);
    chk("rtype.ex_dst", {27'd0, ex_WriteReg_o}, 32'd12);
    chk("addi.mem_dst", {27'd0, mem_WriteReg_o}, 32'd8);
    nop("n0");
    chk("addi.wb_dst", {27'd0, wb_WriteReg_o}, 32'd8);
    chk("addi.wb_rw", {31'd0, wb_RegWrite_o}, 32'd1);

    // Load-use: lw $5, then dependent R-type stalls exactly one cycle
    drive("lw5", 2'b11, 4'b1001, 2'b10, 1'b0, 1'b0, 1'b0, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
    drive("use5a", 2'b10, 4'b0100, 2'b00, 1'b0, 1'b0, 1'b0, 5'd5, 5'd6, 5'd10, 1'b1, 1'b0);
    chk("lw5.mem_rd", {31'd0, mem_MemRead_o}, 32'd1);
    drive("use5b", 2'b10, 4'b0100, 2'b00, 1'b0, 1'b0, 1'b0, 5'd5, 5'd6, 5'd10, 1'b0, 1'b0);

    // lw to $0 never stalls
    drive("lw0", 2'b11, 4'b1001, 2'b10, 1'b0, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    drive("use0", 2'b10, 4'b0100, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);

    // Flush: taken beq, untaken beq, jump
    drive("beq_t", 2'b00, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 1'b1);
    drive("beq_n", 2'b00, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0);
    drive("jmp", 2'b00, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);

    // Stall suppresses flush; branch re-evaluated after the bubble
    drive("lw9", 2'b11, 4'b1001, 2'b10, 1'b0, 1'b0, 1'b0, 5'd2, 5'd9, 5'd0, 1'b0, 1'b0);
    drive("beq9a", 2'b00, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 5'd9, 5'd1, 5'd0, 1'b1, 1'b0);
    drive("beq9b", 2'b00, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 5'd9, 5'd1, 5'd0, 1'b0, 1'b1);

    // lw -> dependent lw -> dependent R-type: one stall per dependency
    drive("lw11", 2'b11, 4'b1001, 2'b10, 1'b0, 1'b0, 1'b0, 5'd1, 5'd11, 5'd0, 1'b0, 1'b0);
    drive("lw12a", 2'b11, 4'b1001, 2'b10, 1'b0, 1'b0, 1'b0, 5'd11, 5'd12, 5'd0, 1'b1, 1'b0);
    drive("lw12b", 2'b11, 4'b1001, 2'b10, 1'b0, 1'b0, 1'b0, 5'd11, 5'd12, 5'd0, 1'b0, 1'b0);
    drive("use12a", 2'b10, 4'b0100, 2'b00, 1'b0, 1'b0, 1'b0, 5'd3, 5'd12, 5'd13, 1'b1, 1'b0);
    drive("use12b", 2'b10, 4'b0100, 2'b00, 1'b0, 1'b0, 1'b0, 5'd3, 5'd12, 5'd13, 1'b0, 1'b0);
    // sw: memwrite travels to mem stage, no destination
    drive("sw", 2'b00, 4'b1001, 2'b01, 1'b0, 1'b0, 1'b0, 5'd1, 5'd13, 5'd0, 1'b0, 1'b0);
    nop("n1");
    nop("n2");
    nop("n3");

    // Reset mid-stream: registers clear asynchronously and the pipe restarts empty
    drive("pre", 2'b11, 4'b1001, 2'b10, 1'b0, 1'b0, 1'b0, 5'd1, 5'd14, 5'd0, 1'b0, 1'b0);
    rst_i = 1'b0;
    sb_reset();
    #1;
    check_stages("arst");
    @(posedge clk_i);
    #1;
    check_stages("arst_hold");
    @(negedge clk_i);
    rst_i = 1'b1;
    drive("post", 2'b10, 4'b0001, 2'b00, 1'b0, 1'b0, 1'b0, 5'd1, 5'd15, 5'd0, 1'b0, 1'b0);
    nop("p1");
    nop("p2");
    chk("post.wb_dst", {27'd0, wb_WriteReg_o}, 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
